// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C client arbiter and driver slice.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } i2c_state_t;

  localparam int unsigned I2C_ADDR_W      = 16;
  localparam int unsigned I2C_DATA_W      = 8;
  localparam int unsigned I2C_TIMEOUT_CYC = 1_000_000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit above `last`, wrapping to 0.
module rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx
);

  // Scan from the farthest candidate down to last+1 so the nearest one wins.
  always_comb begin
    int unsigned p;
    grant = '0;
    idx   = '0;
    p     = 0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      p = (32'(last) + k) % NREQ;
      if (req[p]) begin
        grant    = '0;
        grant[p] = 1'b1;
        idx      = IDXW'(p);
      end
    end
  end

endmodule

// File: rtl/i2c_arb.sv
// Round-robin sequencer sharing one i2c_drv byte engine between NREQ clients,
// with a watchdog that completes a transfer whose done never arrives.
module i2c_arb
  import i2c_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned TIMEOUT_CYC = I2C_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ-1:0]            req_addr_hl,
  input  logic [I2C_ADDR_W*NREQ-1:0] req_word_addr,
  input  logic [I2C_DATA_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]            ack,
  output logic                       err,
  output logic [I2C_DATA_W-1:0]      rdata,
  output logic                       busy,
  output logic                       drv_exec,
  output logic                       drv_we,
  output logic                       drv_addr_hl,
  output logic [I2C_ADDR_W-1:0]      drv_word_addr,
  output logic [I2C_DATA_W-1:0]      drv_wdata,
  input  logic                       drv_done,
  input  logic [I2C_DATA_W-1:0]      drv_rdata
);

  localparam int unsigned IDXW = $clog2(NREQ);
  localparam int unsigned CW   = $clog2(TIMEOUT_CYC);

  i2c_state_t      state;
  logic [IDXW-1:0] last;
  logic [IDXW-1:0] gnt_idx;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] owner;
  logic [CW-1:0]   cnt;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req),
    .last  (last),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last          <= IDXW'(NREQ - 1);
      owner         <= '0;
      cnt           <= '0;
      ack           <= '0;
      err           <= 1'b0;
      rdata         <= '0;
      drv_exec      <= 1'b0;
      drv_we        <= 1'b0;
      drv_addr_hl   <= 1'b0;
      drv_word_addr <= '0;
      drv_wdata     <= '0;
    end else begin
      drv_exec <= 1'b0;
      ack      <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            drv_we        <= req_we[gnt_idx];
            drv_addr_hl   <= req_addr_hl[gnt_idx];
            drv_word_addr <= req_word_addr[I2C_ADDR_W*gnt_idx +: I2C_ADDR_W];
            drv_wdata     <= req_wdata[I2C_DATA_W*gnt_idx +: I2C_DATA_W];
            owner         <= grant;
            last          <= gnt_idx;
            drv_exec      <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done landing on the final watchdog cycle still counts as success.
          if (drv_done) begin
            rdata <= drv_rdata;
            err   <= 1'b0;
            ack   <= owner;
            state <= RESP;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            rdata <= '0;
            err   <= 1'b1;
            ack   <= owner;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
